sync_fifo_param: RTL and testbench

Single-clock, parametrised successor to the team's 4-bit CDC FIFO. It serves same-domain buffering where dual-clock synchronisation is wasted area. It adds:
- width and depth generics
- occupancy count and programmable almost-full / almost-empty flags
- first-word-fall-through (FWFT) or registered-read mode
- synchronous flush
- sticky overflow / underflow error flags

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_param.sv | 142 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock parametrised FIFO: read-mode enum,
// pointer/count width derivation and parameter legality helpers.
package fifo_pkg;

  // Read-side behaviour: registered read or first-word-fall-through.
  typedef enum logic {
    REG_READ = 1'b0,
    FWFT     = 1'b1
  } fifo_mode_e;

  // Address width for a given depth (pointer is one bit wider than this).
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when v is a power of two no smaller than 2.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Full legality check used at elaboration by the top level.
  function automatic bit params_legal(input int width, input int depth,
                                      input int af_thresh, input int ae_thresh);
    return (width >= 1) && is_pow2(depth) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, combinational read port.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// registered-read or FWFT output, synchronous flush and sticky error flags.
module sync_fifo_param #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   winc,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rinc,
  output logic [WIDTH-1:0]       rdata,
  output logic                   wfull,
  output logic                   rempty,
  output logic                   afull,
  output logic                   aempty,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   flush,
  input  logic                   clr_err,
  output logic                   overflow,
  output logic                   underflow
);

  import fifo_pkg::*;

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AE_THRESH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : REG_READ;

  // Refuse to elaborate with an unusable geometry or out-of-range thresholds.
  if (!params_legal(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH/WIDTH/threshold combination");
  end

  logic [ADDR_W:0]  wptr_reg, wptr_next;
  logic [ADDR_W:0]  rptr_reg, rptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             wfull_reg, wfull_next;
  logic             rempty_reg, rempty_next;
  logic             afull_reg, afull_next;
  logic             aempty_reg, aempty_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Accept decisions, next pointers and the flags derived from them.
  // Flags are computed from the post-edge pointers so they are registered
  // but describe the state after the edge with no look-ahead.
  always_comb begin
    wr_acc         = winc && !wfull_reg && !flush;
    rd_acc         = rinc && !rempty_reg && !flush;
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    if (flush) begin
      wptr_next = '0;
      rptr_next = '0;
    end else begin
      wptr_next = wptr_reg + {{ADDR_W{1'b0}}, wr_acc};
      rptr_next = rptr_reg + {{ADDR_W{1'b0}}, rd_acc};
    end
    count_next     = wptr_next - rptr_next;
    wfull_next     = (wptr_next[ADDR_W] != rptr_next[ADDR_W]) &&
                     (wptr_next[ADDR_W-1:0] == rptr_next[ADDR_W-1:0]);
    rempty_next    = (wptr_next == rptr_next);
    afull_next     = (count_next >= AF_LVL);
    aempty_next    = (count_next <= AE_LVL);
    // A fresh error wins over a simultaneous clear; flush masks requests.
    overflow_next  = (overflow_reg && !clr_err) || (winc && wfull_reg && !flush);
    underflow_next = (underflow_reg && !clr_err) || (rinc && rempty_reg && !flush);
  end

  // Pointer, flag and error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      wfull_reg     <= 1'b0;
      rempty_reg    <= 1'b1;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      count_reg     <= count_next;
      wfull_reg     <= wfull_next;
      rempty_reg    <= rempty_next;
      afull_reg     <= afull_next;
      aempty_reg    <= aempty_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_reg[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (rptr_reg[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  if (MODE == REG_READ) begin : g_reg_read
    logic [WIDTH-1:0] rdata_reg;

    // Capture the head word on an accepted read; hold otherwise (also on flush).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_reg <= '0;
      end else if (rd_acc) begin
        rdata_reg <= mem_rdata;
      end
    end

    assign rdata = rdata_reg;
  end else begin : g_fwft
    // Head word is visible whenever the FIFO holds data; zero when empty.
    assign rdata = rempty_reg ? '0 : mem_rdata;
  end

  assign wfull     = wfull_reg;
  assign rempty    = rempty_reg;
  assign afull     = afull_reg;
  assign aempty    = aempty_reg;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance share
// stimulus; a queue-based reference model predicts contents, flags and errors.
module tb_sync_fifo_param;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             winc, rinc, flush, clr_err;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] d0_rdata, d1_rdata;
  logic             d0_wfull, d0_rempty, d0_afull, d0_aempty, d0_ovf, d0_unf;
  logic             d1_wfull, d1_rempty, d1_afull, d1_aempty, d1_ovf, d1_unf;
  logic [3:0]       d0_count, d1_count;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] mq[$];     // model FIFO contents
  logic [WIDTH-1:0] exp_q[$];  // expected registered-read words
  bit               m_ovf, m_unf;
  logic             rd_seen;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(d0_rdata),
    .wfull(d0_wfull), .rempty(d0_rempty), .afull(d0_afull), .aempty(d0_aempty),
    .count(d0_count), .flush(flush), .clr_err(clr_err), .overflow(d0_ovf), .underflow(d0_unf)
  );

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(d1_rdata),
    .wfull(d1_wfull), .rempty(d1_rempty), .afull(d1_afull), .aempty(d1_aempty),
    .count(d1_count), .flush(flush), .clr_err(clr_err), .overflow(d1_ovf), .underflow(d1_unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input logic [3:0] cnt, input logic wf,
                           input logic re, input logic af, input logic ae,
                           input logic ov, input logic un);
    int sz;
    sz = mq.size();
    chk({tag, " count"}, cnt, sz);
    chk({tag, " wfull"}, wf, (sz == DEPTH) ? 1 : 0);
    chk({tag, " rempty"}, re, (sz == 0) ? 1 : 0);
    chk({tag, " afull"}, af, (sz >= AFT) ? 1 : 0);
    chk({tag, " aempty"}, ae, (sz <= AET) ? 1 : 0);
    chk({tag, " overflow"}, ov, m_ovf ? 1 : 0);
    chk({tag, " underflow"}, un, m_unf ? 1 : 0);
  endtask

  task automatic check_all();
    check_dut("d0", d0_count, d0_wfull, d0_rempty, d0_afull, d0_aempty, d0_ovf, d0_unf);
    check_dut("d1", d1_count, d1_wfull, d1_rempty, d1_afull, d1_aempty, d1_ovf, d1_unf);
    chk("d1 fwft rdata", d1_rdata, (mq.size() != 0) ? mq[0] : 4'h0);
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic step(input bit w, input logic [WIDTH-1:0] wd, input bit r,
                      input bit fl = 1'b0, input bit ce = 1'b0);
    bit full, empty;
    winc = w; wdata = wd; rinc = r; flush = fl; clr_err = ce;
    @(posedge clk);
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    m_ovf = (m_ovf && !ce) || (w && full && !fl);
    m_unf = (m_unf && !ce) || (r && empty && !fl);
    if (fl) begin
      mq.delete();
    end else begin
      if (r && !empty) exp_q.push_back(mq.pop_front());
      if (w && !full) mq.push_back(wd);
    end
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0; flush = 1'b0; clr_err = 1'b0;
    $display("step w=%0d wd=%0h r=%0d fl=%0d ce=%0d -> model count=%0d", w, wd, r, fl, ce, mq.size());
    check_all();
  endtask

  // Monitor: note each accepted read seen by the registered-read instance.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= rinc && !d0_rempty && !flush;
  end

  // Monitor: compare the word presented after an accepted read.
  always @(negedge clk) begin
    if (rd_seen && !rst) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL d0 rdata: got %0h with no expected word queued", d0_rdata);
      end else begin
        chk("d0 rdata", d0_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; winc = 0; rinc = 0; flush = 0; clr_err = 0; wdata = '0;
    m_ovf = 0; m_unf = 0;
    repeat (2) @(negedge clk);
    check_all();
    chk("d0 reset rdata", d0_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // Basic write then read.
    step(1, 4'h1, 0); step(1, 4'h2, 0); step(1, 4'h3, 0);
    repeat (3) step(0, 4'h0, 1);
    step(0, 4'h0, 0);

    // Fill past full, then drain.
    for (int i = 0; i < 9; i++) step(1, 4'(i), 0);
    for (int i = 0; i < 8; i++) step(0, 4'h0, 1);
    step(0, 4'h0, 0, 0, 1);

    // Wrap-around.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 6; i++) step(1, 4'($urandom), 0);
      for (int i = 0; i < 6; i++) step(0, 4'h0, 1);
    end

    // Simultaneous read/write at count 4, at full and at empty.
    for (int i = 0; i < 4; i++) step(1, 4'($urandom), 0);
    for (int i = 0; i < 10; i++) step(1, 4'($urandom), 1);
    for (int i = 0; i < 4; i++) step(1, 4'($urandom), 0);
    step(1, 4'($urandom), 1);
    for (int i = 0; i < 7; i++) step(0, 4'h0, 1);
    step(1, 4'($urandom), 1);
    step(0, 4'h0, 1);
    step(0, 4'h0, 0, 0, 1);

    // FWFT presentation of a single word.
    step(1, 4'hA, 0);
    step(0, 4'h0, 0);
    step(0, 4'h0, 1);

    // Flush with an overflow pending, then clear errors.
    for (int i = 0; i < 9; i++) step(1, 4'($urandom), 0);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 1);
    step(1, 4'($urandom), 1, 1, 0);
    step(0, 4'h0, 0, 0, 1);
    step(1, 4'h5, 1, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of a burst, checked before any clock edge.
    for (int i = 0; i < 5; i++) step(1, 4'($urandom), (i > 2));
    winc = 1'b1; wdata = 4'hF;
    #2 rst = 1'b1;
    #1;
    mq.delete(); exp_q.delete(); m_ovf = 0; m_unf = 0;
    check_all();
    chk("d0 async reset rdata", d0_rdata, 0);
    winc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all();
    step(1, 4'h7, 0);
    step(0, 4'h0, 1);
    step(0, 4'h0, 0);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
